// File: rtl/div_ctrl.sv
// div_ctrl: sequencing and operand conditioning for the integer divide path.
// Accepts DIV/DIVU/REM/REMU (and W variants) over a valid/ready handshake.
// Divide-by-zero and signed overflow are resolved here. Other operations are
// sent to an external combinational divider, which is sampled after a fixed
// multicycle window.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous kill; returns to idle and drops the in-flight op
//   in_valid/in_ready  request handshake
//   in1, in2           dividend, divisor
//   control            00 div, 01 divu, 10 rem, 11 remu
//   word               32-bit W variant
//   div_in1/div_in2    conditioned operands to the divider (held stable)
//   div_control        registered control to the divider
//   div_out            divider result
//   out_valid/out_ready result handshake
//   out                64-bit result
module div_ctrl #(
   parameter int unsigned LATENCY = 4  // legal range 1..15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in1,
   input  logic [63:0] in2,
   input  logic [1:0]  control,
   input  logic        word,
   output logic [63:0] div_in1,
   output logic [63:0] div_in2,
   output logic [1:0]  div_control,
   input  logic [63:0] div_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out
);

   localparam int unsigned CntW = 4;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [63:0]       res_q, res_d;
   logic [63:0]       opa_q, opa_d;
   logic [63:0]       opb_q, opb_d;
   logic [1:0]        ctl_q, ctl_d;
   logic              word_q, word_d;

   logic              is_signed;
   logic [63:0]       cond_a, cond_b;
   logic [63:0]       min_val;
   logic              is_zero, is_ovf, is_special;
   logic [63:0]       special_raw, special_res, cap_res;

   // Operand conditioning: W variants take the low word, sign- or zero-extended.
   always_comb begin
      is_signed = ~control[0];
      if (word) begin
         cond_a  = {{32{is_signed & in1[31]}}, in1[31:0]};
         cond_b  = {{32{is_signed & in2[31]}}, in2[31:0]};
         min_val = {{32{1'b1}}, 32'h8000_0000};
      end else begin
         cond_a  = in1;
         cond_b  = in2;
         min_val = {1'b1, 63'd0};
      end
      is_zero    = (cond_b == 64'd0);
      is_ovf     = is_signed & (cond_b == {64{1'b1}}) & (cond_a == min_val);
      is_special = is_zero | is_ovf;
      // control[1] selects remainder
      if (is_zero) begin
         special_raw = control[1] ? cond_a : {64{1'b1}};
      end else begin
         special_raw = control[1] ? 64'd0 : cond_a;
      end
      special_res = word ? {{32{special_raw[31]}}, special_raw[31:0]} : special_raw;
      cap_res     = word_q ? {{32{div_out[31]}}, div_out[31:0]} : div_out;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      ctl_d   = ctl_q;
      word_d  = word_q;
      if (flush) begin
         // Kill wins over accept and over result capture/handshake.
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  opa_d  = cond_a;
                  opb_d  = cond_b;
                  ctl_d  = control;
                  word_d = word;
                  if (is_special) begin
                     res_d   = special_res;
                     state_d = StDone;
                  end else begin
                     cnt_d   = CntW'(LATENCY);
                     state_d = StWait;
                  end
               end
            end
            StWait: begin
               cnt_d = cnt_q - 4'd1;
               // Last cycle of the multicycle window: divider output is settled.
               if (cnt_q == 4'd1) begin
                  res_d   = cap_res;
                  state_d = StDone;
               end
            end
            StDone: begin
               if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         res_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         ctl_q   <= '0;
         word_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         ctl_q   <= ctl_d;
         word_q  <= word_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign out_valid   = (state_q == StDone);
   assign out         = res_q;
   assign div_in1     = opa_q;
   assign div_in2     = opb_q;
   assign div_control = ctl_q;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing and operand-conditioning stage for the integer divide path of the execute unit. Accepts DIV/DIVU/REM/REMU and their 32-bit word variants from issue over a valid/ready handshake. Resolves RISC-V divide-by-zero and signed-overflow cases locally. Otherwise drives the combinational divider through a fixed multicycle window and returns a 64-bit result over a second valid/ready handshake.

## Interface
- LATENCY, 4: cycles the divider inputs are held stable before its output is sampled; legal range 1..15.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in1  input  64  dividend.
- in2  input  64  divisor.
- control  input  2  00 div, 01 divu, 10 rem, 11 remu.
- word  input  1  32-bit W-variant (DIVW/DIVUW/REMW/REMUW).
- div_in1  output  64  conditioned dividend to divider.
- div_in2  output  64  conditioned divisor to divider.
- div_control  output  2  registered control to divider.
- div_out  input  64  divider result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  64  result.

## Operation
- States: IDLE, WAIT, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- Accept when in_valid & in_ready & !flush.
- Conditioning at accept, with signed = !control[0]:
  - word=1: in1/in2 low 32 bits are sign-extended if signed, zero-extended otherwise.
  - word=0: operands pass unchanged.
  - Conditioned values and control are registered and drive div_in1/div_in2/div_control.
- Special cases (evaluated on conditioned operands at accept):
  - Divide by zero (divisor == 0): quotient = all ones; remainder = dividend.
  - Overflow (signed, divisor == all ones, dividend == 64'h8000_0000_0000_0000; word=1: dividend == sign-extended 32'h8000_0000): quotient = dividend; remainder = 0.
  - On a special case, the result register loads directly and the state goes IDLE->DONE.
- Normal case: IDLE->WAIT, counter loads LATENCY.
  - Each WAIT cycle decrements the counter.
  - In the WAIT cycle where the counter equals 1, div_out is captured into the result register and the state goes to DONE.
- Word result: bits 31:0 of the result are sign-extended to 64 bits, for both divider and special-case results.
- DONE: out holds stable. When out_ready is high, the state goes DONE->IDLE.
- flush: from any state, next state is IDLE. The in-flight op is discarded. flush has priority over accept and over out handshake completion.
- Result register holds its last value in IDLE. div_* outputs hold the last conditioned operands.

## Timing
- Reset values: state IDLE (in_ready=1, out_valid=0), out=0, div_in1=0, div_in2=0, div_control=0, counter=0. Reset applies asynchronously at any point, including mid-WAIT.
- Accept at edge T:
  - Special case: out_valid high in cycle T+1.
  - Normal case: WAIT occupies cycles T+1..T+LATENCY; out_valid high in cycle T+LATENCY+1.
- div_in* are stable from cycle T+1 through the capture edge (multicycle path of LATENCY cycles).
- Back-pressure: out_valid remains high with out unchanged until out_ready. in_ready is low in WAIT and DONE.
- Minimum initiation interval: special case 2 cycles (accept, DONE with out_ready=1); normal case LATENCY+2.
- in_valid may drop at any time without effect unless accepted. Inputs are sampled only at the accept edge.

## Test plan
- Normal signed divide: control=00, word=0, in1=-7, in2=2, LATENCY=4 -> out_valid exactly 5 cycles after accept, out=-3. Repeat with control=10 -> out=-1.
- Divide by zero:
  - control=01, in1=42, in2=0 -> out=64'hFFFF_FFFF_FFFF_FFFF one cycle after accept.
  - control=11, same operands -> out=42.
  - Divider outputs are not sampled.
- Overflow:
  - control=00, in1=64'h8000_0000_0000_0000, in2=-1 -> out=64'h8000_0000_0000_0000.
  - word=1, control=10, in1=32'h8000_0000, in2=32'hFFFF_FFFF -> out=0.
- Word unsigned: control=01, word=1, in1=64'hDEAD_BEEF_FFFF_FFFE, in2=1 -> div_in1=64'h0000_0000_FFFF_FFFE, out=64'hFFFF_FFFF_FFFF_FFFE.
- Handshake and flush:
  - Hold out_ready=0 for 10 cycles in DONE -> out stable, in_ready=0.
  - Assert flush in second WAIT cycle -> IDLE next cycle, no out_valid.
- Reset mid-WAIT: drop rst_n asynchronously -> out_valid=0, out=0, in_ready=1 immediately. After release, a new accept completes normally.
